// File: rtl/qspim_pkg.sv
// -----------------------------------------------------------------------------
// qspim_pkg
// Shared types and constants for the QSPI master data path.
//   drain_st_t      : state encoding of the FIFO drain engine
//   BYTES_PER_WORD  : bytes carried by one FIFO word
// -----------------------------------------------------------------------------
package qspim_pkg;

   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } drain_st_t;

endpackage : qspim_pkg

// File: rtl/qspim_fifo.sv
// -----------------------------------------------------------------------------
// qspim_fifo
// Synchronous single-clock data FIFO of the QSPI master.
//   clk, reset_n : clock, synchronous active-low reset
//   wr_en        : push wr_data (ignored when full)
//   wr_data      : word to push
//   full         : no free entry
//   rd_en        : pop head word (ignored when empty)
//   rd_data      : head word; same-cycle when RD_FAST=1, else registered on pop
//   empty        : no stored entry
// -----------------------------------------------------------------------------
module qspim_fifo #(
   parameter int W       = 32,
   parameter int DP      = 4,
   parameter int RD_FAST = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   output logic         full,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic         empty
);

   localparam int             AW    = (DP > 1) ? $clog2(DP) : 1;
   localparam logic [AW:0]    DEPTH = (AW + 1)'(DP);
   localparam logic [AW-1:0]  LAST  = AW'(DP - 1);

   logic [W-1:0]  mem [DP];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_wr;
   logic          do_rd;

   assign full  = (count == DEPTH);
   assign empty = (count == '0);
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;

   // NOTE: storage is deliberately left out of reset; only pointers and count
   // define what is valid, and a reset array would not map onto RAM.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   generate
      if (RD_FAST != 0) begin : g_fast
         assign rd_data = mem[rd_ptr];
      end else begin : g_reg
         logic [W-1:0] rd_q;
         always_ff @(posedge clk) begin
            if (!reset_n)  rd_q <= '0;
            else if (do_rd) rd_q <= mem[rd_ptr];
         end
         assign rd_data = rd_q;
      end
   endgenerate

endmodule : qspim_fifo

// File: rtl/qspim_fifo_drain.sv
// -----------------------------------------------------------------------------
// qspim_fifo_drain
// Pops 32-bit words from the fast-read TX FIFO and streams them LSB byte first
// to the QSPI shifter until the programmed byte count is exhausted.
//   clk, reset_n  : clock, synchronous active-low reset
//   start         : begin a transfer (ignored while busy)
//   byte_cnt      : bytes to send, sampled with an accepted start
//   flush         : synchronous abort back to IDLE, no done pulse
//   fifo_empty    : FIFO empty flag
//   fifo_rd_data  : FIFO head word (valid same cycle)
//   fifo_rd_en    : FIFO pop strobe
//   tx_byte/tx_valid/tx_ready/tx_last : byte stream to the shifter
//   busy          : transfer in progress, LOAD through DONE
//   done          : one-cycle pulse on normal completion
// -----------------------------------------------------------------------------
module qspim_fifo_drain
   import qspim_pkg::*;
#(
   parameter int W  = 32,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic [CW-1:0] byte_cnt,
   input  logic          flush,
   input  logic          fifo_empty,
   input  logic [W-1:0]  fifo_rd_data,
   output logic          fifo_rd_en,
   output logic [7:0]    tx_byte,
   output logic          tx_valid,
   input  logic          tx_ready,
   output logic          tx_last,
   output logic          busy,
   output logic          done
);

   localparam logic [1:0]    LAST_LANE = 2'(BYTES_PER_WORD - 1);
   localparam logic [CW-1:0] ONE       = CW'(1);

   drain_st_t     state;
   logic [CW-1:0] remain;
   logic [1:0]    lane;
   logic [W-1:0]  shreg;
   logic          hs;

   // All stream outputs decode registered state only, so they cannot change
   // while a byte is stalled waiting for tx_ready.
   assign tx_valid   = (state == SHIFT);
   assign tx_byte    = tx_valid ? shreg[7:0] : 8'h00;
   assign tx_last    = tx_valid && (remain == ONE);
   assign busy       = (state != IDLE);
   assign done       = (state == DONE);
   assign hs         = tx_valid && tx_ready;
   // Gated by empty so an underflowing pop is impossible.
   assign fifo_rd_en = (state == LOAD) && !fifo_empty;

   // NOTE: reset is synchronous and shares the flush path, so both abort
   // identically and a byte handshaken in that cycle is never counted.
   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         state  <= IDLE;
         remain <= '0;
         lane   <= '0;
         shreg  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  remain <= byte_cnt;
                  state  <= (byte_cnt == '0) ? DONE : LOAD;
               end
            end
            LOAD: begin
               if (fifo_rd_en) begin
                  shreg <= fifo_rd_data;
                  lane  <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (hs) begin
                  shreg <= shreg >> 8;
                  lane  <= lane + 1'b1;
                  if (remain != '0) remain <= remain - ONE;
                  // Final byte wins over word boundary: unused upper bytes of a
                  // partial last word are simply dropped.
                  if (remain == ONE)         state <= DONE;
                  else if (lane == LAST_LANE) state <= LOAD;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule : qspim_fifo_drain

// File: tb/tb_qspim_fifo_drain.sv
// -----------------------------------------------------------------------------
// tb_qspim_fifo_drain
// Self-checking bench: qspim_fifo (W=32, DP=4, RD_FAST=1) feeds the drain
// engine; expected bytes are derived from the words the bench pushed.
// -----------------------------------------------------------------------------
module tb_qspim_fifo_drain;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [15:0] byte_cnt;
   logic        flush;
   logic        fifo_empty;
   logic        fifo_full;
   logic [31:0] fifo_rd_data;
   logic        fifo_rd_en;
   logic [7:0]  tx_byte;
   logic        tx_valid;
   logic        tx_ready;
   logic        tx_last;
   logic        busy;
   logic        done;
   logic        wr_en;
   logic [31:0] wr_data;

   int tests  = 0;
   int errors = 0;

   logic [31:0] words [4];

   typedef struct {
      logic [15:0] cnt;
      int          mode;     // 0: ready high, 1: random ready, 2: alternating
      int          n_now;    // words pushed before start
      int          n_late;   // words pushed later, from cycle late_at
      int          late_at;
      bit          poke;     // issue a second start while busy
   } vec_t;

   vec_t vecs [4];

   always #5 clk = ~clk;

   qspim_fifo #(.W(32), .DP(4), .RD_FAST(1)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .full    (fifo_full),
      .rd_en   (fifo_rd_en),
      .rd_data (fifo_rd_data),
      .empty   (fifo_empty)
   );

   qspim_fifo_drain #(.W(32), .CW(16)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .byte_cnt     (byte_cnt),
      .flush        (flush),
      .fifo_empty   (fifo_empty),
      .fifo_rd_data (fifo_rd_data),
      .fifo_rd_en   (fifo_rd_en),
      .tx_byte      (tx_byte),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .tx_last      (tx_last),
      .busy         (busy),
      .done         (done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Called and returns on a negedge.
   task automatic push(input logic [31:0] w);
      wr_en   = 1'b1;
      wr_data = w;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic run_xfer(input vec_t v, input int base);
      int          nwords, got, pops, cyc, late_idx;
      bit          prev_stall, prev_last_hs, fin;
      logic [7:0]  held;
      logic [31:0] w;
      nwords = (int'(v.cnt) + 3) / 4;
      for (int i = 0; i < v.n_now; i++) push(words[base + i]);
      got = 0; pops = 0; cyc = 0; late_idx = 0;
      prev_stall = 0; prev_last_hs = 0; fin = 0; held = '0;
      start    = 1'b1;
      byte_cnt = v.cnt;
      @(negedge clk);
      start = 1'b0;
      while (!fin && cyc < 300) begin
         case (v.mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = 1'($urandom_range(0, 1));
            default: tx_ready = cyc[0];
         endcase
         start    = v.poke && (cyc == 3);
         byte_cnt = (v.poke && cyc == 3) ? 16'd2 : v.cnt;
         if (late_idx < v.n_late && cyc >= v.late_at) begin
            wr_en   = 1'b1;
            wr_data = words[base + v.n_now + late_idx];
            late_idx++;
         end else begin
            wr_en = 1'b0;
         end
         check("rd_en_while_empty", {31'd0, fifo_rd_en && fifo_empty}, 32'd0);
         check("busy_during_xfer", {31'd0, busy}, 32'd1);
         if (fifo_rd_en) pops++;
         if (prev_stall) begin
            check("stall_hold_valid", {31'd0, tx_valid}, 32'd1);
            check("stall_hold_byte", {24'd0, tx_byte}, {24'd0, held});
         end
         if (done) begin
            check("done_after_last_hs", {31'd0, prev_last_hs}, 32'd1);
            check("byte_total", got, {16'd0, v.cnt});
            fin = 1;
         end else if (tx_valid) begin
            if (got < int'(v.cnt)) begin
               w = words[base + got / 4] >> (8 * (got % 4));
               check("tx_byte", {24'd0, tx_byte}, {24'd0, w[7:0]});
               check("tx_last", {31'd0, tx_last}, {31'd0, got == int'(v.cnt) - 1});
            end else begin
               check("no_extra_byte", {31'd0, tx_valid}, 32'd0);
            end
         end
         prev_last_hs = tx_valid && tx_ready && tx_last;
         prev_stall   = tx_valid && !tx_ready;
         held         = tx_byte;
         if (tx_valid && tx_ready) got++;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0; wr_en = 1'b0; tx_ready = 1'b0; byte_cnt = '0;
      check("xfer_finished", {31'd0, fin}, 32'd1);
      check("pop_count", pops, nwords);
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("idle_after_done", {31'd0, busy}, 32'd0);
      check("fifo_drained", {31'd0, fifo_empty}, 32'd1);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_rd_en"},    {31'd0, fifo_rd_en}, 32'd0);
      check({tag, "_tx_valid"}, {31'd0, tx_valid},   32'd0);
      check({tag, "_tx_byte"},  {24'd0, tx_byte},    32'd0);
      check({tag, "_tx_last"},  {31'd0, tx_last},    32'd0);
      check({tag, "_busy"},     {31'd0, busy},       32'd0);
      check({tag, "_done"},     {31'd0, done},       32'd0);
   endtask

   initial begin
      int   hs, cyc;
      vec_t v4;
      words[0] = 32'h4433_2211;
      words[1] = 32'h8877_6655;
      words[2] = 32'hCCBB_AA99;
      words[3] = 32'h1E2D_3C4B;
      //            cnt    mode n_now n_late late_at poke
      vecs[0] = '{16'd8,  0,   2,    0,     0,      0};  // basic transfer
      vecs[1] = '{16'd5,  0,   2,    0,     0,      0};  // partial word
      vecs[2] = '{16'd12, 1,   1,    2,     25,     0};  // backpressure + starvation
      vecs[3] = '{16'd8,  2,   2,    0,     0,      1};  // start while busy
      v4      = '{16'd4,  0,   0,    0,     0,      0};  // word already in FIFO

      reset_n = 1'b0; start = 1'b0; byte_cnt = '0; flush = 1'b0;
      tx_ready = 1'b0; wr_en = 1'b0; wr_data = '0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      check("reset_fifo_empty", {31'd0, fifo_empty}, 32'd1);
      check("reset_fifo_full", {31'd0, fifo_full}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 4; i++) run_xfer(vecs[i], 0);

      // Zero count: done next cycle, no pop although the FIFO holds a word.
      push(words[0]);
      start = 1'b1; byte_cnt = 16'd0;
      @(negedge clk);
      start = 1'b0;
      check("zero_done", {31'd0, done}, 32'd1);
      check("zero_busy", {31'd0, busy}, 32'd1);
      check("zero_no_pop", {31'd0, fifo_rd_en}, 32'd0);
      check("zero_no_valid", {31'd0, tx_valid}, 32'd0);
      @(negedge clk);
      check("zero_done_pulse", {31'd0, done}, 32'd0);
      check("zero_idle", {31'd0, busy}, 32'd0);
      check("zero_word_kept", {31'd0, fifo_empty}, 32'd0);
      run_xfer(v4, 0);

      // Flush while the 4th of 8 bytes is offered and accepted.
      push(words[0]);
      push(words[1]);
      start = 1'b1; byte_cnt = 16'd8; tx_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      hs = 0; cyc = 0;
      while (hs < 3 && cyc < 50) begin
         if (tx_valid) hs++;
         @(negedge clk);
         cyc++;
      end
      check("flush_three_hs", hs, 3);
      check("flush_4th_valid", {31'd0, tx_valid}, 32'd1);
      check("flush_4th_byte", {24'd0, tx_byte}, 32'h44);
      flush = 1'b1; start = 1'b1; byte_cnt = 16'd3;
      @(negedge clk);
      flush = 1'b0; start = 1'b0; tx_ready = 1'b0;
      check_reset_values("flush");
      repeat (3) begin
         @(negedge clk);
         check("flush_no_done", {31'd0, done}, 32'd0);
         check("flush_stays_idle", {31'd0, busy}, 32'd0);
      end
      run_xfer(v4, 1);  // word1 still queued: bytes 55,66,77,88

      // Reset in SHIFT.
      push(words[2]);
      start = 1'b1; byte_cnt = 16'd4;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!tx_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("rst_reached_shift", {31'd0, tx_valid}, 32'd1);
      reset_n = 1'b0;
      @(negedge clk);
      check_reset_values("rst_shift");
      reset_n = 1'b1;
      @(negedge clk);
      run_xfer(vecs[0], 0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule : tb_qspim_fifo_drain
